// File: rtl/core_run_ctrl_pkg.sv
// Shared encodings for the run-control sequencer: FSM states, exec/idle
// qualifier levels and the HALT opcode seen in the writeback stage.
package core_run_ctrl_pkg;

   localparam int DATA_W = 16;
   localparam int OP_W   = 5;

   // Pipeline qualifier levels driven on `state`
   localparam logic ST_EXEC = 1'b1;
   localparam logic ST_IDLE = 1'b0;

   // Opcode [15:11] of the HALT instruction
   localparam logic [OP_W-1:0] OP_HALT = 5'h1F;

   typedef enum logic [2:0] {
      CTRL_IDLE  = 3'd0,
      CTRL_CLEAR = 3'd1,
      CTRL_RUN   = 3'd2,
      CTRL_PAUSE = 3'd3,
      CTRL_STEP  = 3'd4,
      CTRL_HALT  = 3'd5
   } ctrl_state_e;

   // The host may only write instruction memory while the core is stopped
   function automatic logic load_allowed(input ctrl_state_e s);
      return (s == CTRL_IDLE) || (s == CTRL_PAUSE) || (s == CTRL_HALT);
   endfunction

   // Pipeline stages only advance in these states
   function automatic logic is_exec(input ctrl_state_e s);
      return (s == CTRL_RUN) || (s == CTRL_STEP);
   endfunction

endpackage

// File: rtl/core_run_ctrl_loader.sv
// Instruction-memory write port: captures one accepted host load per cycle
// and presents it as a single-cycle write on the following cycle.
import core_run_ctrl_pkg::*;

module imem_loader #(
   parameter int ADDR_W = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              load_ok,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   output logic              i_we,
   output logic [ADDR_W-1:0] i_waddr,
   output logic [DATA_W-1:0] i_wdata
);

   logic i_we_q;
   logic [ADDR_W-1:0] i_waddr_q;
   logic [DATA_W-1:0] i_wdata_q;

   // Ready depends only on the FSM state, never on ld_valid
   assign ld_ready = load_ok;

   // Register the accepted load; address/data hold when nothing is accepted
   always_ff @(posedge clock) begin
      if (reset) begin
         i_we_q    <= 1'b0;
         i_waddr_q <= '0;
         i_wdata_q <= '0;
      end else begin
         i_we_q <= ld_valid && load_ok;
         if (ld_valid && load_ok) begin
            i_waddr_q <= ld_addr;
            i_wdata_q <= ld_data;
         end
      end
   end

   assign i_we    = i_we_q;
   assign i_waddr = i_waddr_q;
   assign i_wdata = i_wdata_q;

endmodule

// File: rtl/core_run_ctrl.sv
// Run-control sequencer: drives the exec/idle qualifier and the active-low
// core reset, counts exec cycles, detects HALT / watchdog expiry and gates
// host loads into instruction memory.
import core_run_ctrl_pkg::*;

module core_run_ctrl #(
   parameter logic [15:0] TIMEOUT = 16'd0,
   parameter int          ADDR_W  = 8
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              start,
   input  logic              stop,
   input  logic              resume,
   input  logic              step,
   input  logic [OP_W-1:0]   wb_op,
   input  logic              ld_valid,
   input  logic [ADDR_W-1:0] ld_addr,
   input  logic [DATA_W-1:0] ld_data,
   output logic              ld_ready,
   output logic              state,
   output logic              core_reset,
   output logic              i_we,
   output logic [ADDR_W-1:0] i_waddr,
   output logic [DATA_W-1:0] i_wdata,
   output logic [15:0]       cycle_cnt,
   output logic              halted,
   output logic              timeout
);

   ctrl_state_e fsm_q, fsm_d;
   logic        state_q, core_reset_q, halted_q, timeout_q;
   logic [15:0] cnt_q;
   logic        halt_hit, wd_hit;

   // cnt_q counts completed exec cycles, so it equals TIMEOUT-1 during the last allowed one
   assign halt_hit = (wb_op == OP_HALT);
   assign wd_hit   = (TIMEOUT != 16'd0) && (cnt_q == TIMEOUT - 16'd1);

   // Next-state selection with the per-state pulse priorities
   always_comb begin
      fsm_d = fsm_q;
      unique case (fsm_q)
         CTRL_IDLE:  if (start) fsm_d = CTRL_CLEAR;
         CTRL_CLEAR: fsm_d = CTRL_RUN;
         CTRL_RUN: begin
            if (halt_hit || wd_hit) fsm_d = CTRL_HALT;
            else if (start)         fsm_d = CTRL_CLEAR;
            else if (stop)          fsm_d = CTRL_PAUSE;
         end
         CTRL_PAUSE: begin
            if (start)       fsm_d = CTRL_CLEAR;
            else if (resume) fsm_d = CTRL_RUN;
            else if (step)   fsm_d = CTRL_STEP;
         end
         CTRL_STEP:  fsm_d = (halt_hit || wd_hit) ? CTRL_HALT : CTRL_PAUSE;
         CTRL_HALT:  if (start) fsm_d = CTRL_CLEAR;
         default:    fsm_d = CTRL_IDLE;
      endcase
   end

   // State register; outputs are computed from the next state so they line up with it
   always_ff @(posedge clock) begin
      if (reset) begin
         fsm_q        <= CTRL_IDLE;
         state_q      <= ST_IDLE;
         core_reset_q <= 1'b0;
         cnt_q        <= 16'd0;
         halted_q     <= 1'b0;
         timeout_q    <= 1'b0;
      end else begin
         fsm_q        <= fsm_d;
         state_q      <= is_exec(fsm_d) ? ST_EXEC : ST_IDLE;
         core_reset_q <= !((fsm_d == CTRL_IDLE) || (fsm_d == CTRL_CLEAR));
         if (fsm_d == CTRL_CLEAR) begin
            cnt_q     <= 16'd0;
            halted_q  <= 1'b0;
            timeout_q <= 1'b0;
         end else begin
            if (is_exec(fsm_q) && (cnt_q != 16'hFFFF))
               cnt_q <= cnt_q + 16'd1;
            // HALT opcode outranks the watchdog when both fire together
            if ((fsm_d == CTRL_HALT) && (fsm_q != CTRL_HALT)) begin
               halted_q  <= 1'b1;
               timeout_q <= wd_hit && !halt_hit;
            end
         end
      end
   end

   imem_loader #(.ADDR_W(ADDR_W)) u_loader (
      .clock    (clock),
      .reset    (reset),
      .load_ok  (load_allowed(fsm_q)),
      .ld_valid (ld_valid),
      .ld_addr  (ld_addr),
      .ld_data  (ld_data),
      .ld_ready (ld_ready),
      .i_we     (i_we),
      .i_waddr  (i_waddr),
      .i_wdata  (i_wdata)
   );

   assign state      = state_q;
   assign core_reset = core_reset_q;
   assign cycle_cnt  = cnt_q;
   assign halted     = halted_q;
   assign timeout    = timeout_q;

endmodule

// File: tb/tb_core_run_ctrl.sv
// Directed bench for core_run_ctrl: one instance without watchdog, one with
// TIMEOUT = 5, both driven by the same stimulus.
module tb_core_run_ctrl;

   logic        clock = 1'b0;
   logic        reset = 1'b0, start = 1'b0, stop = 1'b0, resume = 1'b0, step = 1'b0;
   logic [4:0]  wb_op = 5'd0;
   logic        ld_valid = 1'b0;
   logic [7:0]  ld_addr = 8'd0;
   logic [15:0] ld_data = 16'd0;

   logic        ld_ready, state, core_reset, i_we, halted, timeout;
   logic [7:0]  i_waddr;
   logic [15:0] i_wdata, cycle_cnt;

   logic        w_ld_ready, w_state, w_core_reset, w_i_we, w_halted, w_timeout;
   logic [7:0]  w_i_waddr;
   logic [15:0] w_i_wdata, w_cycle_cnt;

   localparam logic [4:0] HALT_OP = 5'h1F;

   int passed = 0;
   int total  = 0;

   always #5 clock = ~clock;

   core_run_ctrl #(.TIMEOUT(16'd0), .ADDR_W(8)) dut (
      .clock(clock), .reset(reset), .start(start), .stop(stop), .resume(resume),
      .step(step), .wb_op(wb_op), .ld_valid(ld_valid), .ld_addr(ld_addr),
      .ld_data(ld_data), .ld_ready(ld_ready), .state(state), .core_reset(core_reset),
      .i_we(i_we), .i_waddr(i_waddr), .i_wdata(i_wdata), .cycle_cnt(cycle_cnt),
      .halted(halted), .timeout(timeout)
   );

   core_run_ctrl #(.TIMEOUT(16'd5), .ADDR_W(8)) dut_wd (
      .clock(clock), .reset(reset), .start(start), .stop(stop), .resume(resume),
      .step(step), .wb_op(wb_op), .ld_valid(ld_valid), .ld_addr(ld_addr),
      .ld_data(ld_data), .ld_ready(w_ld_ready), .state(w_state), .core_reset(w_core_reset),
      .i_we(w_i_we), .i_waddr(w_i_waddr), .i_wdata(w_i_wdata), .cycle_cnt(w_cycle_cnt),
      .halted(w_halted), .timeout(w_timeout)
   );

   // Advance one clock and sample just after the edge
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      cyc();
      cyc();
      total++;
      if ({state, core_reset, i_we, i_waddr, i_wdata, cycle_cnt, halted, timeout, ld_ready} !==
          {1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1})
         $display("FAIL reset_main got st=%b cr=%b we=%b a=%h d=%h cnt=%0d h=%b t=%b rdy=%b",
                  state, core_reset, i_we, i_waddr, i_wdata, cycle_cnt, halted, timeout, ld_ready);
      else passed++;
      total++;
      if ({w_state, w_core_reset, w_i_we, w_i_waddr, w_i_wdata, w_cycle_cnt, w_halted, w_timeout, w_ld_ready} !==
          {1'b0, 1'b0, 1'b0, 8'h00, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1})
         $display("FAIL reset_wd got st=%b cr=%b we=%b a=%h d=%h cnt=%0d h=%b t=%b rdy=%b",
                  w_state, w_core_reset, w_i_we, w_i_waddr, w_i_wdata, w_cycle_cnt, w_halted, w_timeout, w_ld_ready);
      else passed++;
      reset = 1'b0;
   endtask

   task automatic test_load();
      ld_valid = 1'b1; ld_addr = 8'h00; ld_data = 16'h1234;
      cyc();
      total++;
      if ({i_we, i_waddr, i_wdata} !== {1'b1, 8'h00, 16'h1234})
         $display("FAIL load0 got we=%b a=%h d=%h exp we=1 a=00 d=1234", i_we, i_waddr, i_wdata);
      else passed++;
      ld_addr = 8'h01; ld_data = 16'h5678;
      cyc();
      total++;
      if ({i_we, i_waddr, i_wdata} !== {1'b1, 8'h01, 16'h5678})
         $display("FAIL load1 got we=%b a=%h d=%h exp we=1 a=01 d=5678", i_we, i_waddr, i_wdata);
      else passed++;
      ld_valid = 1'b0;
      cyc();
      total++;
      if ({i_we, i_waddr, i_wdata} !== {1'b0, 8'h01, 16'h5678})
         $display("FAIL load_hold got we=%b a=%h d=%h exp we=0 a=01 d=5678", i_we, i_waddr, i_wdata);
      else passed++;
   endtask

   task automatic test_start();
      start = 1'b1;
      cyc();
      start = 1'b0;
      total++;
      if ({state, core_reset, cycle_cnt} !== {1'b0, 1'b0, 16'd0})
         $display("FAIL start_clear got st=%b cr=%b cnt=%0d exp st=0 cr=0 cnt=0", state, core_reset, cycle_cnt);
      else passed++;
      for (int k = 0; k < 4; k++) begin
         cyc();
         total++;
         if ({state, core_reset, ld_ready, cycle_cnt} !== {1'b1, 1'b1, 1'b0, 16'(k)})
            $display("FAIL run_count%0d got st=%b cr=%b rdy=%b cnt=%0d exp st=1 cr=1 rdy=0 cnt=%0d",
                     k, state, core_reset, ld_ready, cycle_cnt, k);
         else passed++;
      end
   endtask

   task automatic test_halt();
      int guard = 0;
      while (cycle_cnt != 16'd9 && guard < 50) begin
         cyc();
         guard++;
      end
      total++;
      if (cycle_cnt !== 16'd9 || state !== 1'b1)
         $display("FAIL halt_reach got cnt=%0d st=%b exp cnt=9 st=1", cycle_cnt, state);
      else passed++;
      wb_op = HALT_OP;
      cyc();
      wb_op = 5'd0;
      total++;
      if ({state, core_reset, halted, timeout, cycle_cnt} !== {1'b0, 1'b1, 1'b1, 1'b0, 16'd10})
         $display("FAIL halt_enter got st=%b cr=%b h=%b t=%b cnt=%0d exp st=0 cr=1 h=1 t=0 cnt=10",
                  state, core_reset, halted, timeout, cycle_cnt);
      else passed++;
      resume = 1'b1; step = 1'b1;
      cyc();
      resume = 1'b0; step = 1'b0;
      cyc();
      total++;
      if ({state, halted, cycle_cnt, ld_ready} !== {1'b0, 1'b1, 16'd10, 1'b1})
         $display("FAIL halt_stay got st=%b h=%b cnt=%0d rdy=%b exp st=0 h=1 cnt=10 rdy=1",
                  state, halted, cycle_cnt, ld_ready);
      else passed++;
   endtask

   task automatic test_step();
      start = 1'b1;
      cyc();
      start = 1'b0;
      cyc(); cyc(); cyc();
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      total++;
      if ({state, core_reset, cycle_cnt, ld_ready} !== {1'b0, 1'b1, 16'd3, 1'b1})
         $display("FAIL pause got st=%b cr=%b cnt=%0d rdy=%b exp st=0 cr=1 cnt=3 rdy=1",
                  state, core_reset, cycle_cnt, ld_ready);
      else passed++;
      cyc();
      step = 1'b1;
      cyc();
      step = 1'b0;
      total++;
      if ({state, cycle_cnt} !== {1'b1, 16'd3})
         $display("FAIL step_exec got st=%b cnt=%0d exp st=1 cnt=3", state, cycle_cnt);
      else passed++;
      cyc();
      total++;
      if ({state, cycle_cnt} !== {1'b0, 16'd4})
         $display("FAIL step_back got st=%b cnt=%0d exp st=0 cnt=4", state, cycle_cnt);
      else passed++;
      resume = 1'b1;
      cyc();
      resume = 1'b0;
      for (int k = 0; k < 3; k++) begin
         total++;
         if ({state, cycle_cnt} !== {1'b1, 16'(4 + k)})
            $display("FAIL resume%0d got st=%b cnt=%0d exp st=1 cnt=%0d", k, state, cycle_cnt, 4 + k);
         else passed++;
         cyc();
      end
   endtask

   task automatic test_watchdog();
      int execs = 0;
      int guard = 0;
      start = 1'b1;
      cyc();
      start = 1'b0;
      total++;
      if ({w_halted, w_timeout, w_cycle_cnt, w_core_reset} !== {1'b0, 1'b0, 16'd0, 1'b0})
         $display("FAIL wd_clear got h=%b t=%b cnt=%0d cr=%b exp h=0 t=0 cnt=0 cr=0",
                  w_halted, w_timeout, w_cycle_cnt, w_core_reset);
      else passed++;
      while (!w_halted && guard < 20) begin
         cyc();
         guard++;
         if (w_state) execs++;
      end
      total++;
      if (execs != 5 || {w_halted, w_timeout, w_cycle_cnt, w_state} !== {1'b1, 1'b1, 16'd5, 1'b0})
         $display("FAIL wd_expire got execs=%0d h=%b t=%b cnt=%0d st=%b exp execs=5 h=1 t=1 cnt=5 st=0",
                  execs, w_halted, w_timeout, w_cycle_cnt, w_state);
      else passed++;
      start = 1'b1;
      cyc();
      start = 1'b0;
      total++;
      if ({w_halted, w_timeout, w_cycle_cnt} !== {1'b0, 1'b0, 16'd0})
         $display("FAIL wd_restart got h=%b t=%b cnt=%0d exp h=0 t=0 cnt=0", w_halted, w_timeout, w_cycle_cnt);
      else passed++;
   endtask

   task automatic test_gating();
      int bad = 0;
      cyc();
      ld_valid = 1'b1; ld_addr = 8'h33; ld_data = 16'hAAAA;
      for (int k = 0; k < 4; k++) begin
         cyc();
         if (ld_ready !== 1'b0 || i_we !== 1'b0 || state !== 1'b1) bad++;
      end
      ld_valid = 1'b0;
      total++;
      if (bad != 0)
         $display("FAIL run_gate got %0d cycles with rdy/we set exp 0", bad);
      else passed++;
      stop = 1'b1; wb_op = HALT_OP;
      cyc();
      stop = 1'b0; wb_op = 5'd0;
      total++;
      if ({state, halted, timeout} !== {1'b0, 1'b1, 1'b0})
         $display("FAIL stop_vs_halt got st=%b h=%b t=%b exp st=0 h=1 t=0", state, halted, timeout);
      else passed++;
      start = 1'b1; ld_valid = 1'b1; ld_addr = 8'h42; ld_data = 16'hBEEF;
      #1;
      total++;
      if (ld_ready !== 1'b1)
         $display("FAIL halt_ready got rdy=%b exp 1", ld_ready);
      else passed++;
      cyc();
      start = 1'b0; ld_valid = 1'b0;
      total++;
      if ({core_reset, halted, i_we, i_waddr, i_wdata} !== {1'b0, 1'b0, 1'b1, 8'h42, 16'hBEEF})
         $display("FAIL load_in_clear got cr=%b h=%b we=%b a=%h d=%h exp cr=0 h=0 we=1 a=42 d=beef",
                  core_reset, halted, i_we, i_waddr, i_wdata);
      else passed++;
      cyc();
      total++;
      if ({state, i_we} !== {1'b1, 1'b0})
         $display("FAIL after_clear got st=%b we=%b exp st=1 we=0", state, i_we);
      else passed++;
   endtask

   task automatic test_reset_mid();
      stop = 1'b1;
      cyc();
      stop = 1'b0;
      step = 1'b1;
      cyc();
      step = 1'b0;
      total++;
      if (state !== 1'b1)
         $display("FAIL mid_step_enter got st=%b exp 1", state);
      else passed++;
      reset = 1'b1;
      cyc();
      reset = 1'b0;
      total++;
      if ({state, core_reset, i_we, cycle_cnt, halted, timeout, ld_ready} !==
          {1'b0, 1'b0, 1'b0, 16'd0, 1'b0, 1'b0, 1'b1})
         $display("FAIL reset_in_step got st=%b cr=%b we=%b cnt=%0d h=%b t=%b rdy=%b",
                  state, core_reset, i_we, cycle_cnt, halted, timeout, ld_ready);
      else passed++;
      stop = 1'b1; resume = 1'b1; step = 1'b1;
      cyc();
      stop = 1'b0; resume = 1'b0; step = 1'b0;
      cyc();
      total++;
      if ({state, core_reset} !== {1'b0, 1'b0})
         $display("FAIL idle_ignore got st=%b cr=%b exp st=0 cr=0", state, core_reset);
      else passed++;
      ld_valid = 1'b1; ld_addr = 8'h07; ld_data = 16'h7777;
      cyc();
      ld_valid = 1'b0;
      reset = 1'b1;
      total++;
      if ({i_we, i_waddr} !== {1'b1, 8'h07})
         $display("FAIL pre_reset_load got we=%b a=%h exp we=1 a=07", i_we, i_waddr);
      else passed++;
      cyc();
      reset = 1'b0;
      total++;
      if ({i_we, i_waddr, i_wdata, core_reset} !== {1'b0, 8'h00, 16'h0000, 1'b0})
         $display("FAIL reset_after_load got we=%b a=%h d=%h cr=%b exp we=0 a=00 d=0000 cr=0",
                  i_we, i_waddr, i_wdata, core_reset);
      else passed++;
      ld_valid = 1'b1; ld_addr = 8'h09; ld_data = 16'h9999; reset = 1'b1;
      cyc();
      ld_valid = 1'b0; reset = 1'b0;
      total++;
      if ({i_we, i_waddr, i_wdata} !== {1'b0, 8'h00, 16'h0000})
         $display("FAIL reset_with_load got we=%b a=%h d=%h exp we=0 a=00 d=0000", i_we, i_waddr, i_wdata);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_load();
      test_start();
      test_halt();
      test_step();
      test_watchdog();
      test_gating();
      test_reset_mid();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
